// File: rtl/processor_unit_if.sv
// Bus bundle for processor_unit: data sources, select, raw flags and the
// registered data/status/phase outputs.
interface processor_unit_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] i_data;
  logic              data_select;
  logic [15:0]       status_flags;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        status;
  logic [2:0]        Q;

  modport master (
    output data_in, i_data, data_select, status_flags,
    input  data_out, status, Q
  );

  modport slave (
    input  data_in, i_data, data_select, status_flags,
    output data_out, status, Q
  );
endinterface

// File: rtl/processor_unit.sv
// Registered data mux, packed status capture and 3-bit phase counter.
// Optional macro STATUS_HOLD_EN: status_flags[15]=1 freezes the status register.
module processor_unit #(
  parameter int          DATA_W     = 32,
  parameter logic [7:0]  STATUS_RST = 8'b0110_0000
) (
  input  logic             clk,
  input  logic             rst,
  processor_unit_if.slave  bus
);

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [7:0]        status_q,   status_d;
  logic [2:0]        q_q,        q_d;
  logic [7:0]        status_packed;
  logic              unused_flags;

  // Bits [6:5] of the packed word are reserved and always read back as 1.
  assign status_packed = {bus.status_flags[7], 2'b11, bus.status_flags[4:0]};
  assign unused_flags  = ^{bus.status_flags[15:8], bus.status_flags[6:5]};

  always_comb begin
    data_out_d = bus.data_select ? bus.i_data : bus.data_in;
    q_d        = q_q + 3'd1;
`ifdef STATUS_HOLD_EN
    status_d   = bus.status_flags[15] ? status_q : status_packed;
`else
    status_d   = status_packed;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      status_q   <= STATUS_RST;
      q_q        <= 3'd0;
    end else begin
      data_out_q <= data_out_d;
      status_q   <= status_d;
      q_q        <= q_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.status   = status_q;
  assign bus.Q        = q_q;

endmodule

// File: tb/tb_processor_unit.sv
// Directed bench for processor_unit: reset values, source select, status
// packing, sample-edge behaviour, mid-run reset and phase counter wrap.
module tb_processor_unit;

  localparam int DATA_W = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  processor_unit_if #(.DATA_W(DATA_W)) bus ();

  processor_unit #(.DATA_W(DATA_W), .STATUS_RST(8'b0110_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack_status(input logic [15:0] f);
    return {f[7], 1'b1, 1'b1, f[4], f[3], f[2], f[1:0]};
  endfunction

  logic [31:0] r_din, r_idat, old_out;
  logic        r_sel;
  logic [15:0] r_flags;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.data_in      = 32'hA5A5_A5A5;
    bus.i_data       = 32'h5A5A_5A5A;
    bus.data_select  = 1'b1;
    bus.status_flags = 16'h00FF;
    tick();
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_status",   {24'h0, bus.status}, 32'h60);
    check("rst_q",        {29'h0, bus.Q}, 32'h0);

    rst = 1'b0;
    bus.data_in      = 32'h1234_5678;
    bus.i_data       = 32'hDEAD_BEEF;
    bus.data_select  = 1'b0;
    bus.status_flags = 16'h0000;
    tick();
    check("sel0_data_out", bus.data_out, 32'h1234_5678);
    check("flags0_status", {24'h0, bus.status}, 32'h60);
    check("q_1",           {29'h0, bus.Q}, 32'h1);

    bus.data_select = 1'b1;
    tick();
    check("sel1_data_out", bus.data_out, 32'hDEAD_BEEF);
    check("q_2",           {29'h0, bus.Q}, 32'h2);

    bus.status_flags = 16'hFFFF;
    tick();
`ifndef STATUS_HOLD_EN
    check("status_all_ones", {24'h0, bus.status}, 32'hFF);
`endif
    check("q_3", {29'h0, bus.Q}, 32'h3);

    bus.status_flags = 16'h0015;
    tick();
    check("status_0015", {24'h0, bus.status}, 32'h75);

    bus.status_flags = 16'h0080;
    tick();
    check("status_0080", {24'h0, bus.status}, 32'hE0);

    bus.status_flags = 16'h7F60;
    tick();
    check("status_ignored_bits", {24'h0, bus.status}, 32'h60);
    check("q_6", {29'h0, bus.Q}, 32'h6);

    // Changes between edges must not reach the registered output.
    bus.data_select = 1'b0;
    bus.data_in     = 32'hCAFE_0001;
    tick();
    old_out = bus.data_out;
    check("edge_capture", old_out, 32'hCAFE_0001);
    #2 bus.data_in = 32'hBAD0_BAD0;
    #2 check("mid_cycle_hold", bus.data_out, 32'hCAFE_0001);

    rst = 1'b1;
    tick();
    check("midrst_data_out", bus.data_out, 32'h0);
    check("midrst_status",   {24'h0, bus.status}, 32'h60);
    check("midrst_q",        {29'h0, bus.Q}, 32'h0);
    bus.data_in = 32'h1111_2222;
    tick();
    check("rst_hold_data_out", bus.data_out, 32'h0);
    check("rst_hold_q",        {29'h0, bus.Q}, 32'h0);

    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      r_din   = $urandom;
      r_idat  = $urandom;
      r_sel   = 1'($urandom_range(0, 1));
      r_flags = 16'($urandom) & 16'h7FFF;
      bus.data_in      = r_din;
      bus.i_data       = r_idat;
      bus.data_select  = r_sel;
      bus.status_flags = r_flags;
      tick();
      check($sformatf("rand%0d_data_out", i), bus.data_out, r_sel ? r_idat : r_din);
      check($sformatf("rand%0d_status", i), {24'h0, bus.status}, {24'h0, pack_status(r_flags)});
      check($sformatf("rand%0d_q", i), {29'h0, bus.Q}, i);
    end

    for (int i = 4; i <= 7; i++) tick();
    check("q_7", {29'h0, bus.Q}, 32'h7);
    tick();
    check("q_wrap", {29'h0, bus.Q}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
